// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//
// Instruction-fetch stage of the pipelined MIPS core. Owns the program
// counter, generates the fetch address for instruction memory, PC+4 for the
// IF/ID register and the IF/ID write/flush controls. Chooses the next PC from
// the sequential, branch, jump, interrupt-vector and ERET-return sources, and
// keeps the saved return address (EPC) plus the interrupt-handler mask state.
//
// Ports
//   clk            in   1  rising-edge clock
//   rst1           in   1  synchronous, active-high reset
//   pcw            in   1  PC write enable from the hazard unit (0 = stall)
//   branch_taken   in   1  branch resolved taken in ID
//   branch_target  in  32  branch destination
//   jump           in   1  J/JAL/JR resolved in ID
//   jump_target    in  32  jump destination
//   eret           in   1  ERET decoded in ID
//   int_req        in   1  external interrupt request (pulse or level)
//   pc             out 32  current fetch address
//   npc4           out 32  pc + 4 (wraps modulo 2^32)
//   ifidw          out  1  IF/ID write enable
//   if_flush       out  1  IF/ID clear (squash the fetched instruction)
//   epc            out 32  saved return address
//   in_handler     out  1  1 while the state machine is in HANDLER
//
// Handshake: there is no valid/ready pair here. pcw acts as the single
// "advance" qualifier: when it is low every PC/EPC/state update and every
// redirect request is ignored, and ID keeps presenting its request until
// pcw returns high. Only int_pending keeps listening to int_req during a
// stall, so a short request pulse is never lost.
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst1,
  input  logic        pcw,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        eret,
  input  logic        int_req,
  output logic [31:0] pc,
  output logic [31:0] npc4,
  output logic        ifidw,
  output logic        if_flush,
  output logic [31:0] epc,
  output logic        in_handler
);

  // Two-state machine: RUN accepts interrupts, HANDLER masks them.
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_HANDLER = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_int_pending;

  logic [31:0] w_npc4;
  logic [31:0] w_seq_next;
  logic        w_redirect;
  logic        w_do_eret;
  logic        w_accept;
  logic        w_flush;

  // ---------------------------------------------------------------------------
  // Next-PC candidates
  // ---------------------------------------------------------------------------
  assign w_npc4 = r_pc + 32'd4;

  // Branch has priority over jump; both are used unmasked.
  always_comb begin
    w_seq_next = w_npc4;
    if (branch_taken) begin
      w_seq_next = branch_target;
    end else if (jump) begin
      w_seq_next = jump_target;
    end
  end

  assign w_redirect = branch_taken | jump;

  // ERET only counts inside the handler; in RUN it falls through to the
  // ordinary sequential/redirect decision.
  assign w_do_eret = pcw & (r_state == ST_HANDLER) & eret;

  // Acceptance is blocked by ERET only structurally: the two conditions need
  // different states, so they can never both be true.
  assign w_accept  = pcw & (r_state == ST_RUN) & r_int_pending;

  // ---------------------------------------------------------------------------
  // IF/ID controls
  // ---------------------------------------------------------------------------
  // On acceptance the fetched instruction is only wrong if ID is redirecting,
  // which is the same condition as an ordinary redirect, so accept and
  // redirect share the flush term.
  always_comb begin
    w_flush = 1'b0;
    if (!rst1 && pcw) begin
      if (w_do_eret) begin
        w_flush = 1'b1;
      end else if (w_accept) begin
        w_flush = w_redirect;
      end else begin
        w_flush = w_redirect;
      end
    end
  end

  assign if_flush = w_flush;
  assign ifidw    = pcw & ~rst1;
  assign npc4     = w_npc4;

  // ---------------------------------------------------------------------------
  // State, PC, EPC and pending-interrupt registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst1) begin
      r_pc          <= RESET_PC;
      r_epc         <= 32'h0000_0000;
      r_int_pending <= 1'b0;
      r_state       <= ST_RUN;
    end else begin
      // Pending latch listens even during stalls; the accept edge clears it
      // and that clear beats a simultaneous request.
      if (w_accept) begin
        r_int_pending <= 1'b0;
      end else if (int_req) begin
        r_int_pending <= 1'b1;
      end

      if (pcw) begin
        if (w_do_eret) begin
          r_pc    <= r_epc;
          r_state <= ST_RUN;
        end else if (w_accept) begin
          // Return to wherever the program would have gone next, including a
          // branch/jump resolved on this same edge.
          r_epc   <= w_seq_next;
          r_pc    <= INT_VECTOR;
          r_state <= ST_HANDLER;
        end else begin
          r_pc <= w_seq_next;
        end
      end
    end
  end

  assign pc         = r_pc;
  assign epc        = r_epc;
  assign in_handler = (r_state == ST_HANDLER);

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        rst1;
  logic        pcw;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        eret;
  logic        int_req;
  logic [31:0] pc;
  logic [31:0] npc4;
  logic        ifidw;
  logic        if_flush;
  logic [31:0] epc;
  logic        in_handler;

  int n_checks;
  int n_fail;

  // Reference model state: what the fetch stage should look like after each edge.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  bit          m_pend;
  bit          m_handler;

  if_stage dut (
    .clk           (clk),
    .rst1          (rst1),
    .pcw           (pcw),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .eret          (eret),
    .int_req       (int_req),
    .pc            (pc),
    .npc4          (npc4),
    .ifidw         (ifidw),
    .if_flush      (if_flush),
    .epc           (epc),
    .in_handler    (in_handler)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] model_seq();
    if (branch_taken) return branch_target;
    if (jump) return jump_target;
    return m_pc + 32'd4;
  endfunction

  // The instruction in IF is wrong whenever ID redirects or an ERET returns.
  function automatic bit model_flush();
    if (rst1 || !pcw) return 1'b0;
    return (m_handler && eret) || branch_taken || jump;
  endfunction

  task automatic model_edge();
    logic [31:0] seq;
    bit          pend_n;
    seq = model_seq();
    if (rst1) begin
      m_pc = 32'h0; m_epc = 32'h0; m_pend = 1'b0; m_handler = 1'b0;
    end else begin
      pend_n = m_pend | int_req;
      if (pcw) begin
        if (m_handler && eret) begin
          m_pc = m_epc; m_handler = 1'b0;
        end else if (!m_handler && m_pend) begin
          m_epc = seq; m_pc = 32'h180; m_handler = 1'b1; pend_n = 1'b0;
        end else begin
          m_pc = seq;
        end
      end
      m_pend = pend_n;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    pcw = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0; eret = 1'b0; int_req = 1'b0;
  endtask

  // One clock: edge, model update, then settle at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic jump_to(input logic [31:0] tgt);
    idle_inputs();
    jump = 1'b1; jump_target = tgt;
    tick();
    idle_inputs();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst1 = 1'b1;
    @(negedge clk);
    tick();
    tick();
    #1;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_checks++; if (ifidw !== 1'b0) begin n_fail++; $display("FAIL reset_ifidw: got %b want 0", ifidw); end
    n_checks++; if (if_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", if_flush); end
    n_checks++; if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h want 0", epc); end
    n_checks++; if (in_handler !== 1'b0) begin n_fail++; $display("FAIL reset_handler: got %b want 0", in_handler); end
    rst1 = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 32'(4 * i)); end
      n_checks++; if (npc4 !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL seq_npc4[%0d]: got %h want %h", i, npc4, 32'(4 * i + 4)); end
      n_checks++; if (if_flush !== 1'b0 || ifidw !== 1'b1) begin n_fail++; $display("FAIL seq_ctl[%0d]: got flush=%b ifidw=%b want 0/1", i, if_flush, ifidw); end
      tick();
      #1;
    end
    jump_to(32'hFFFF_FFFC);
    n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h want fffffffc", pc); end
    n_checks++; if (npc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_npc4: got %h want 0", npc4); end
    tick();
    #1;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got %h want 0", pc); end
  endtask

  task automatic test_stall();
    jump_to(32'h10);
    pcw = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 10", i, pc); end
      n_checks++; if (ifidw !== 1'b0 || if_flush !== 1'b0) begin n_fail++; $display("FAIL stall_ctl[%0d]: got ifidw=%b flush=%b want 0/0", i, ifidw, if_flush); end
      tick();
    end
    pcw = 1'b1;
    #1;
    n_checks++; if (if_flush !== 1'b1) begin n_fail++; $display("FAIL stall_release_flush: got %b want 1", if_flush); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL stall_release_pc: got %h want 200", pc); end
  endtask

  task automatic test_branch();
    logic [31:0] epc_before;
    jump_to(32'h20);
    epc_before = m_epc;
    branch_taken = 1'b1; branch_target = 32'h100;
    #1;
    n_checks++; if (if_flush !== 1'b1) begin n_fail++; $display("FAIL branch_flush: got %b want 1", if_flush); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL branch_pc: got %h want 100", pc); end
    n_checks++; if (epc !== epc_before) begin n_fail++; $display("FAIL branch_epc: got %h want %h", epc, epc_before); end
  endtask

  task automatic test_interrupt();
    jump_to(32'h40);
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h44 || in_handler !== 1'b0) begin n_fail++; $display("FAIL int_pre: got pc=%h h=%b want 44/0", pc, in_handler); end
    n_checks++; if (if_flush !== 1'b0) begin n_fail++; $display("FAIL int_accept_flush: got %b want 0", if_flush); end
    tick();
    #1;
    n_checks++; if (epc !== 32'h48 || pc !== 32'h180 || in_handler !== 1'b1) begin n_fail++; $display("FAIL int_entry: got epc=%h pc=%h h=%b want 48/180/1", epc, pc, in_handler); end
    for (int i = 0; i < 4; i++) tick();
    #1;
    n_checks++; if (pc !== 32'h190) begin n_fail++; $display("FAIL int_handler_seq: got %h want 190", pc); end
    eret = 1'b1;
    #1;
    n_checks++; if (if_flush !== 1'b1) begin n_fail++; $display("FAIL eret_flush: got %b want 1", if_flush); end
    tick();
    eret = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h48 || in_handler !== 1'b0) begin n_fail++; $display("FAIL eret_return: got pc=%h h=%b want 48/0", pc, in_handler); end
  endtask

  task automatic test_int_branch();
    jump_to(32'h60);
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h300;
    #1;
    n_checks++; if (if_flush !== 1'b1) begin n_fail++; $display("FAIL intbr_flush: got %b want 1", if_flush); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (epc !== 32'h300 || pc !== 32'h180 || in_handler !== 1'b1) begin n_fail++; $display("FAIL intbr_entry: got epc=%h pc=%h h=%b want 300/180/1", epc, pc, in_handler); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h300) begin n_fail++; $display("FAIL intbr_return: got %h want 300", pc); end
  endtask

  task automatic test_masked();
    jump_to(32'h40);
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    tick();
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h184 || in_handler !== 1'b1) begin n_fail++; $display("FAIL mask_seq: got pc=%h h=%b want 184/1", pc, in_handler); end
    tick();
    #1;
    n_checks++; if (pc !== 32'h188) begin n_fail++; $display("FAIL mask_no_reentry: got %h want 188", pc); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h48) begin n_fail++; $display("FAIL mask_eret: got %h want 48", pc); end
    tick();
    #1;
    n_checks++; if (epc !== 32'h4C || pc !== 32'h180) begin n_fail++; $display("FAIL mask_accept: got epc=%h pc=%h want 4c/180", epc, pc); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_handler();
    jump_to(32'h80);
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    tick();
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h0 || epc !== 32'h0 || in_handler !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got pc=%h epc=%h h=%b want 0/0/0", pc, epc, in_handler); end
    tick();
    tick();
    #1;
    n_checks++; if (pc !== 32'h8 || in_handler !== 1'b0) begin n_fail++; $display("FAIL rst_pend_drop: got pc=%h h=%b want 8/0", pc, in_handler); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst1          = ($urandom_range(99) < 2);
      pcw           = ($urandom_range(99) < 80);
      branch_taken  = ($urandom_range(99) < 20);
      branch_target = $urandom;
      jump          = ($urandom_range(99) < 15);
      jump_target   = $urandom;
      eret          = ($urandom_range(99) < 25);
      int_req       = ($urandom_range(99) < 12);
      #1;
      n_checks++; if (npc4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_npc4[%0d]: got %h want %h", i, npc4, m_pc + 32'd4); end
      n_checks++; if (ifidw !== (pcw & ~rst1)) begin n_fail++; $display("FAIL rnd_ifidw[%0d]: got %b want %b", i, ifidw, pcw & ~rst1); end
      n_checks++; if (if_flush !== model_flush()) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, if_flush, model_flush()); end
      tick();
      #1;
      n_checks++; if (pc !== m_pc || epc !== m_epc || in_handler !== m_handler) begin n_fail++; $display("FAIL rnd_regs[%0d]: got pc=%h epc=%h h=%b want %h/%h/%b", i, pc, epc, in_handler, m_pc, m_epc, m_handler); end
    end
    idle_inputs();
    rst1 = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_pc = 32'h0; m_epc = 32'h0; m_pend = 1'b0; m_handler = 1'b0;
    rst1 = 1'b1;
    idle_inputs();
    test_reset();
    test_stall();
    test_branch();
    test_interrupt();
    test_int_branch();
    test_masked();
    test_reset_mid_handler();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS core. It sits directly upstream of the IF/ID pipeline register: it owns the program counter and produces the fetch address for instruction memory. It also produces the PC+4 value and the write/flush controls for IF/ID. It selects the next PC from sequential, branch, jump, interrupt-vector and ERET-return sources, and holds the EPC and the interrupt-handler mask state.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset
- INT_VECTOR, 32'h0000_0180, handler entry address
- clk  in  1  rising-edge clock
- rst1  in  1  synchronous, active-high reset
- pcw  in  1  PC write enable from hazard unit; 0 = stall
- branch_taken  in  1  branch resolved taken in ID
- branch_target  in  32  branch destination
- jump  in  1  J/JAL/JR resolved in ID
- jump_target  in  32  jump destination
- eret  in  1  ERET decoded in ID
- int_req  in  1  external interrupt request (pulse or level)
- pc  out  32  current fetch address to instruction memory
- npc4  out  32  pc+4, to IF/ID pcin
- ifidw  out  1  IF/ID write enable
- if_flush  out  1  IF/ID clear; top ORs it into the IF/ID clear path
- epc  out  32  saved return address
- in_handler  out  1  1 while in state HANDLER

## Operation
- Clocking: one clock, clk. Reset rst1 is synchronous and active-high.
- Registers: pc, epc, int_pending, and state (RUN, HANDLER).
- Reset values: pc=RESET_PC, epc=0, int_pending=0, state=RUN. While rst1=1: ifidw=0 and if_flush=0.
- No branch delay slot. Branches and jumps resolve in ID, so the instruction in IF is squashed on redirect.
- npc4 = pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0). Targets and vector are used unmasked.
- seq_next is the "normal" next PC:
  - branch_target if branch_taken
  - else jump_target if jump
  - else npc4
- int_pending:
  - Set on any edge with int_req=1.
  - Cleared on the accept edge; clear wins over set on that edge.
  - A still-high int_req re-sets it on the next edge.
- ifidw = pcw & ~rst1.
- When pcw=0: pc, epc and state hold. branch_taken, jump, eret and acceptance are all ignored, and if_flush=0. ID holds these requests, so they are re-presented once pcw=1.
- Decision each edge with pcw=1, in priority order:
  1. **ERET:** state=HANDLER and eret → pc<=epc, state<=RUN, if_flush=1. ERET wins over branch/jump and over a pending interrupt. eret in RUN is ignored (treated as sequential).
  2. **Accept:** state=RUN and int_pending → epc<=seq_next, pc<=INT_VECTOR, state<=HANDLER, int_pending<=0. if_flush equals branch_taken|jump, because the fetched instruction is valid only on the sequential path.
  3. **Redirect:** branch_taken or jump → pc<=seq_next, if_flush=1.
  4. **Sequential:** pc<=npc4, if_flush=0.
- In HANDLER, interrupts are masked: int_pending may be set but is not accepted. It is accepted on the first edge after the ERET edge, with pcw=1.
- Reset mid-handler: state returns to RUN, pending is dropped, and epc is cleared.

## Timing
- pc, epc, state and int_pending update on the rising edge of clk only.
- if_flush, ifidw and npc4 are combinational from the current state and inputs, and are valid before the edge at which IF/ID samples.
- Fetch latency: pc is presented the cycle it is registered, and IF/ID captures {npc4, instr} at the next edge.
- Interrupt latency, with no stalls:
  - int_req sampled at edge N.
  - Accept at edge N+1.
  - INT_VECTOR fetched in the cycle after N+1.
- Each stall cycle delays acceptance by one cycle.
- Redirect penalty: one squashed fetch, as a bubble in IF/ID.

## Test plan
- **Reset and wrap:** hold rst1=1 for 2 cycles with pcw=1 → pc=0, ifidw=0. Release → pc 0x0, 0x4, 0x8, npc4 = pc+4, if_flush=0. Force pc to 0xFFFF_FFFC via jump → next pc=0x0.
- **Stall:** at pc=0x10 drive pcw=0 for 3 cycles, with branch_taken=1 and target 0x200 → pc stays 0x10, ifidw=0, if_flush=0. Then pcw=1 with branch still asserted → if_flush=1, next pc=0x200.
- **Branch:** at pc=0x20, branch_taken=1, target 0x100 → if_flush=1, next pc=0x100, epc unchanged.
- **Interrupt entry/return:** 1-cycle int_req while pc=0x40 → next cycle pc=0x44 and accept: epc=0x48, pc=0x180, in_handler=1, if_flush=0. eret at pc=0x190 → if_flush=1, pc=0x48, in_handler=0.
- **Interrupt with branch:** int_pending=1 in RUN while branch_taken=1, target 0x300 → epc=0x300, pc=0x180, if_flush=1.
- **Masked interrupt:** int_req pulse while in_handler=1 → no vector re-entry, pc sequential. After ERET to 0x48, the next edge accepts: epc=0x4C, pc=0x180.
